// File: rtl/uart_tx_sched_if.sv
// Signal bundle between the host-side byte sources / UART transmitter and the
// round-robin transmit scheduler, including the shared oversampling baud tick.
interface uart_tx_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int DIV_W   = 16
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [DIV_W-1:0]          baud_div;
  logic                      tick;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      tx_start;
  logic [DATA_W-1:0]         tx_data;
  logic                      tx_busy;
  logic [ID_W-1:0]           grant_id;
  logic                      frame_done;

  modport master (
    output baud_div, req_valid, req_data, tx_busy,
    input  tick, req_ready, tx_start, tx_data, grant_id, frame_done
  );

  modport slave (
    input  baud_div, req_valid, req_data, tx_busy,
    output tick, req_ready, tx_start, tx_data, grant_id, frame_done
  );
endinterface

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler that feeds one UART transmitter from NUM_REQ byte
// sources, plus the programmable 16x-oversampling baud tick generator.
module uart_tx_sched #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int DIV_W   = 16
) (
  input logic            clk,
  input logic            rst_n,
  uart_tx_sched_if.slave bus
);
  localparam int            ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [ID_W:0] NUM_REQ_W = (ID_W+1)'(NUM_REQ);

  typedef enum logic [2:0] {
    IDLE,
    ACCEPT,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  state_t state, state_next;

  logic [DIV_W-1:0] div_cnt;
  logic             tick_en;
  logic             div_hit;

  // The >= compare lets a shrinking divisor wrap immediately instead of
  // counting all the way around; divisors 0 and 1 mean a tick every cycle.
  always_comb begin
    div_hit = (bus.baud_div <= DIV_W'(1)) ||
              (div_cnt >= (bus.baud_div - DIV_W'(1)));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt <= '0;
      tick_en <= 1'b0;
    end else begin
      div_cnt <= div_hit ? '0 : div_cnt + DIV_W'(1);
      tick_en <= 1'b1;
    end
  end

  assign bus.tick = tick_en & div_hit;

  logic [ID_W-1:0] rr_ptr, rr_next;
  logic [ID_W-1:0] grant_q, grant_next;
  logic [ID_W-1:0] pick;
  logic            pick_found;
  logic [ID_W:0]   pick_inc;

  // First valid requester at or after the rotating pointer, modulo NUM_REQ.
  always_comb begin
    logic [ID_W:0] idx;
    idx        = '0;
    pick       = '0;
    pick_found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = {1'b0, rr_ptr} + (ID_W+1)'(i);
      if (idx >= NUM_REQ_W) begin
        idx = idx - NUM_REQ_W;
      end
      if (!pick_found && bus.req_valid[idx[ID_W-1:0]]) begin
        pick       = idx[ID_W-1:0];
        pick_found = 1'b1;
      end
    end
  end

  always_comb begin
    pick_inc = {1'b0, pick} + (ID_W+1)'(1);
    if (pick_inc >= NUM_REQ_W) begin
      pick_inc = '0;
    end
  end

  logic [DATA_W-1:0] slice [NUM_REQ];

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      slice[i] = bus.req_data[i*DATA_W +: DATA_W];
    end
  end

  logic [2:0]         wait_cnt, wait_next;
  logic [DATA_W-1:0]  tx_data_q, tx_data_next;
  logic               done_q, done_next;
  logic [NUM_REQ-1:0] ready_vec;
  logic               start_pulse;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      grant_q   <= '0;
      rr_ptr    <= '0;
      wait_cnt  <= '0;
      tx_data_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_next;
      grant_q   <= grant_next;
      rr_ptr    <= rr_next;
      wait_cnt  <= wait_next;
      tx_data_q <= tx_data_next;
      done_q    <= done_next;
    end
  end

  // A launch that never raises tx_busy is abandoned after eight idle cycles
  // so one lost frame cannot stall every other requester.
  always_comb begin
    state_next   = state;
    grant_next   = grant_q;
    rr_next      = rr_ptr;
    wait_next    = wait_cnt;
    tx_data_next = tx_data_q;
    done_next    = 1'b0;
    ready_vec    = '0;
    start_pulse  = 1'b0;
    case (state)
      IDLE: begin
        if (!bus.tx_busy && pick_found) begin
          grant_next = pick;
          rr_next    = pick_inc[ID_W-1:0];
          state_next = ACCEPT;
        end
      end
      ACCEPT: begin
        ready_vec    = NUM_REQ'(1) << grant_q;
        tx_data_next = slice[grant_q];
        state_next   = LAUNCH;
      end
      LAUNCH: begin
        start_pulse = 1'b1;
        wait_next   = '0;
        state_next  = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (bus.tx_busy) begin
          state_next = WAIT_DONE;
        end else if (wait_cnt == 3'd7) begin
          state_next = IDLE;
        end else begin
          wait_next = wait_cnt + 3'd1;
        end
      end
      WAIT_DONE: begin
        if (!bus.tx_busy) begin
          done_next  = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.req_ready  = ready_vec;
  assign bus.tx_start   = start_pulse;
  assign bus.tx_data    = tx_data_q;
  assign bus.grant_id   = grant_q;
  assign bus.frame_done = done_q;
endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a transaction-level model.
module tb_uart_tx_sched;
  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 8;
  localparam int DIV_W   = 16;

  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  uart_tx_sched_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .DIV_W(DIV_W)) bus ();

  uart_tx_sched #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .DIV_W(DIV_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Transmitter stand-in: busy for busy_len cycles per launch, or never when dropped.
  int   busy_len  = 20;
  int   busy_left = 0;
  logic tx_drop   = 1'b0;
  logic rand_tx   = 1'b0;

  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      busy_left = 0;
    end else if (bus.tx_start) begin
      if (tx_drop || (rand_tx && $urandom_range(0, 7) == 0)) busy_left = 0;
      else busy_left = rand_tx ? int'($urandom_range(2, 6)) : busy_len;
    end else if (busy_left > 0) begin
      busy_left--;
    end else if (rand_tx && $urandom_range(0, 31) == 0) begin
      busy_left = int'($urandom_range(1, 3));
    end
    bus.tx_busy = (busy_left > 0);
  end

  // Reference model: predicted outputs for the coming cycle, derived from
  // "cycles since grant" and round-robin arithmetic over the valid set.
  logic                model_valid = 1'b0;
  int                  m_cnt, m_last, m_age, m_quiet;
  logic                m_run, m_active, m_seen_busy;
  logic [NUM_REQ-1:0]  e_ready;
  logic                e_start, e_done, e_tick;
  logic [DATA_W-1:0]   e_data;
  int                  e_grant;
  int                  grant_log[$];
  logic [DATA_W-1:0]   data_log[$];

  always @(negedge clk) begin
    int div;
    int first;
    logic hit;
    logic [NUM_REQ*DATA_W-1:0] rd;
    div = int'(bus.baud_div);
    if (model_valid) begin
      e_tick = m_run && (div <= 1 || m_cnt >= div - 1);
      checkOutput("req_ready", 32'(bus.req_ready), 32'(e_ready));
      checkOutput("tx_start", 32'(bus.tx_start), 32'(e_start));
      checkOutput("tx_data", 32'(bus.tx_data), 32'(e_data));
      checkOutput("grant_id", 32'(bus.grant_id), 32'(e_grant));
      checkOutput("frame_done", 32'(bus.frame_done), 32'(e_done));
      checkOutput("tick", 32'(bus.tick), 32'(e_tick));
      checkOutput("ready_onehot", 32'($countones(bus.req_ready) <= 1), 32'd1);
      if (bus.req_ready != '0) grant_log.push_back(int'(bus.grant_id));
      if (bus.tx_start) data_log.push_back(bus.tx_data);
    end
    if (!rst_n) begin
      m_cnt = 0; m_run = 1'b0; m_active = 1'b0; m_last = -1;
      m_age = 0; m_quiet = 0; m_seen_busy = 1'b0;
      e_ready = '0; e_start = 1'b0; e_done = 1'b0; e_data = '0; e_grant = 0;
    end else begin
      hit   = (div <= 1) || (m_cnt >= div - 1);
      m_cnt = hit ? 0 : m_cnt + 1;
      m_run = 1'b1;
      e_ready = '0; e_start = 1'b0; e_done = 1'b0;
      if (!m_active) begin
        if (!bus.tx_busy && bus.req_valid != '0) begin
          first = (m_last + 1) % NUM_REQ;
          for (int k = 0; k < NUM_REQ; k++) begin
            if (!m_active && bus.req_valid[(first + k) % NUM_REQ]) begin
              e_grant  = (first + k) % NUM_REQ;
              m_last   = e_grant;
              m_active = 1'b1;
              m_age    = 1;
              e_ready  = NUM_REQ'(1) << e_grant;
            end
          end
        end
      end else if (m_age == 1) begin
        rd      = bus.req_data;
        e_data  = rd[e_grant*DATA_W +: DATA_W];
        e_start = 1'b1;
        m_age   = 2;
      end else if (m_age == 2) begin
        m_age = 3; m_quiet = 0; m_seen_busy = 1'b0;
      end else if (!m_seen_busy) begin
        if (bus.tx_busy) m_seen_busy = 1'b1;
        else begin
          m_quiet++;
          if (m_quiet == 8) m_active = 1'b0;
        end
      end else if (!bus.tx_busy) begin
        e_done   = 1'b1;
        m_active = 1'b0;
      end
    end
    model_valid = 1'b1;
  end

  int                 ready_at, start_at, done_at;
  logic [NUM_REQ-1:0] ready_bits;
  logic [DATA_W-1:0]  start_data;

  task automatic applyStimulus(input logic [NUM_REQ-1:0] valid,
                               input logic [NUM_REQ*DATA_W-1:0] data);
    bus.req_valid = valid;
    bus.req_data  = data;
  endtask

  task automatic applyReset();
    rst_n = 1'b0;
    applyStimulus('0, '0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    grant_log.delete();
    data_log.delete();
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Records first ready/start/done cycle relative to the call; sources drop valid once accepted.
  task automatic trackCycles(input int n_cycles);
    logic [NUM_REQ-1:0] seen;
    ready_at = -1; start_at = -1; done_at = -1; ready_bits = '0; start_data = '0;
    for (int n = 0; n < n_cycles; n++) begin
      @(negedge clk);
      seen = bus.req_ready;
      if (seen != '0 && ready_at < 0) begin ready_at = n; ready_bits = seen; end
      if (bus.tx_start && start_at < 0) begin start_at = n; start_data = bus.tx_data; end
      if (bus.frame_done && done_at < 0) done_at = n;
      @(posedge clk);
      #1;
      bus.req_valid = bus.req_valid & ~seen;
    end
  endtask

  task automatic waitGrants(input int n, input int limit);
    for (int k = 0; k < limit && (grant_log.size() < n || data_log.size() < n); k++) begin
      @(negedge clk);
    end
    checkOutput("grant_count", 32'(grant_log.size() >= n && data_log.size() >= n), 32'd1);
    @(posedge clk);
    #1;
  endtask

  function automatic int grantAt(input int i);
    return (i < grant_log.size()) ? grant_log[i] : -1;
  endfunction

  function automatic int dataAt(input int i);
    return (i < data_log.size()) ? int'(data_log[i]) : -1;
  endfunction

  initial begin
    logic [31:0] mask;
    logic [NUM_REQ-1:0] v;
    logic [NUM_REQ-1:0] seen;
    logic [NUM_REQ*DATA_W-1:0] d;
    int exp_grant[5];
    int exp_data[5];
    exp_grant = '{0, 1, 2, 3, 0};
    exp_data  = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h11};
    bus.baud_div = DIV_W'(4);
    rst_n = 1'b0;
    applyStimulus('0, '0);

    $display("[TB] tick generator");
    applyReset();
    mask = '0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      mask[n] = bus.tick;
    end
    checkOutput("tick_div4_pattern", mask, 32'h888);
    @(posedge clk);
    #1 bus.baud_div = '0;
    mask = '0;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      mask[n] = bus.tick;
    end
    checkOutput("tick_div0_pattern", mask, 32'h1F);
    @(posedge clk);
    #1 bus.baud_div = DIV_W'(5);

    $display("[TB] single request");
    busy_len = 20;
    applyReset();
    applyStimulus(4'b0001, 32'h000000A5);
    trackCycles(30);
    checkOutput("single_ready_at", 32'(ready_at), 32'd1);
    checkOutput("single_ready_bits", 32'(ready_bits), 32'b0001);
    checkOutput("single_start_at", 32'(start_at), 32'd2);
    checkOutput("single_start_data", 32'(start_data), 32'hA5);
    checkOutput("single_done_at", 32'(done_at), 32'd23);

    $display("[TB] four requesters held");
    busy_len = 3;
    applyReset();
    applyStimulus(4'b1111, 32'h44332211);
    waitGrants(5, 200);
    for (int i = 0; i < 5; i++) begin
      checkOutput("rr4_grant", 32'(grantAt(i)), 32'(exp_grant[i]));
      checkOutput("rr4_data", 32'(dataAt(i)), 32'(exp_data[i]));
    end
    applyStimulus('0, '0);
    idleCycles(20);

    $display("[TB] requesters 1 and 3");
    applyReset();
    applyStimulus(4'b0010, 32'h0000BB00);
    waitGrants(1, 50);
    applyStimulus(4'b1010, 32'hDD00BB00);
    waitGrants(3, 200);
    checkOutput("rr13_first", 32'(grantAt(0)), 32'd1);
    checkOutput("rr13_second", 32'(grantAt(1)), 32'd3);
    checkOutput("rr13_third", 32'(grantAt(2)), 32'd1);
    applyStimulus('0, '0);
    idleCycles(20);

    $display("[TB] lost launch");
    applyReset();
    tx_drop = 1'b1;
    applyStimulus(4'b0100, 32'h00CC0000);
    trackCycles(6);
    checkOutput("lost_ready_bits", 32'(ready_bits), 32'b0100);
    checkOutput("lost_start_at", 32'(start_at), 32'd2);
    checkOutput("lost_no_done", 32'(done_at), 32'hFFFF_FFFF);
    tx_drop = 1'b0;
    applyStimulus(bus.req_valid | 4'b0010, 32'h00CCEE00);
    trackCycles(20);
    checkOutput("after_lost_ready_at", 32'(ready_at), 32'd6);
    checkOutput("after_lost_ready_bits", 32'(ready_bits), 32'b0010);
    checkOutput("after_lost_data", 32'(start_data), 32'hEE);
    checkOutput("after_lost_done_at", 32'(done_at), 32'd11);
    idleCycles(10);

    $display("[TB] reset during frame");
    busy_len = 20;
    applyReset();
    applyStimulus(4'b0100, 32'h005A0000);
    trackCycles(10);
    rst_n = 1'b0;
    applyStimulus(4'b1010, 32'h77006600);
    @(negedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("rst_req_ready", 32'(bus.req_ready), 32'd0);
    checkOutput("rst_tx_start", 32'(bus.tx_start), 32'd0);
    checkOutput("rst_tx_data", 32'(bus.tx_data), 32'd0);
    checkOutput("rst_grant_id", 32'(bus.grant_id), 32'd0);
    checkOutput("rst_frame_done", 32'(bus.frame_done), 32'd0);
    checkOutput("rst_tick", 32'(bus.tick), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    trackCycles(10);
    checkOutput("post_rst_ready_at", 32'(ready_at), 32'd1);
    checkOutput("post_rst_ready_bits", 32'(ready_bits), 32'b0010);
    checkOutput("post_rst_data", 32'(start_data), 32'h66);
    applyStimulus('0, '0);
    idleCycles(40);

    $display("[TB] randomized traffic");
    rand_tx = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      seen = bus.req_ready;
      @(posedge clk);
      #1;
      v = bus.req_valid & ~seen;
      d = bus.req_data;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!v[i] && $urandom_range(0, 3) == 0) begin
          v[i] = 1'b1;
          d[i*DATA_W +: DATA_W] = DATA_W'($urandom_range(0, 255));
        end
      end
      if ($urandom_range(0, 199) == 0) bus.baud_div = DIV_W'($urandom_range(0, 9));
      applyStimulus(v, d);
    end
    rand_tx = 1'b0;
    applyStimulus('0, '0);
    idleCycles(60);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "[TB] simulation did not finish in time");
  end
endmodule
